pipelined_cla_adder: RTL
========================

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits; SHALL be a multiple of 4, minimum 4.
REQ-002 Port: clk  input  1  rising-edge clock; one clock domain only.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  operand set present.
REQ-005 Port: in_ready  output  1  stage 1 can accept operands this cycle.
REQ-006 Port: A  input  WIDTH  operand A, two's complement.
REQ-007 Port: B  input  WIDTH  operand B, two's complement.
REQ-008 Port: C_in  input  1  carry-in; used only when sub=0.
REQ-009 Port: sub  input  1  0 = A+B+C_in; 1 = A-B (A + ~B + 1; C_in ignored).
REQ-010 Port: out_valid  output  1  result registers hold a valid result.
REQ-011 Port: out_ready  input  1  consumer accepts the result this cycle.
REQ-012 Port: S  output  WIDTH  sum/difference.
REQ-013 Port: C_out  output  1  carry out of the MSB; for sub=1, 1 means no borrow.
REQ-014 Port: overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
REQ-015 Port: zero  output  1  S == 0.

Function
REQ-016 The block SHALL be a two-stage pipeline:
- Stage 1 registers A, B^{WIDTH{sub}}, the effective carry-in (sub ? 1 : C_in), and a valid bit.
- Stage 2 registers S, C_out, overflow, zero, and a valid bit.
REQ-017 The stage 1 to stage 2 logic SHALL use 4-bit groups with per-bit generate/propagate, group Pg/Gg, and a second-level lookahead across groups; no ripple carry across group boundaries.
REQ-018 Stage 2 advance condition: adv2 = !s2_valid || out_ready.
REQ-019 Stage 1 advance condition: adv1 = !s1_valid || adv2.
REQ-020 in_ready SHALL equal adv1, combinationally.
REQ-021 Operands SHALL be captured into stage 1 only when in_valid && in_ready.
REQ-022 On adv1, s1_valid SHALL load in_valid.
REQ-023 On adv2, s2_valid SHALL load s1_valid, and the result registers SHALL load only if s1_valid.
REQ-024 When a stage does not advance, it SHALL hold all of its registers unchanged (stall), so a backpressured result is held stable.
REQ-025 Latency: operands accepted at edge t SHALL appear with out_valid=1 after edge t+2 when out_ready stays high.
REQ-026 Throughput SHALL be one result per cycle with in_valid and out_ready continuously high.
REQ-027 Simultaneous out_ready and in_valid with a full pipeline SHALL accept, shift and retire in the same cycle, with no bubble and no loss.
REQ-028 S, C_out, overflow and zero SHALL be outputs of registers only, with no combinational path from inputs.
REQ-029 The block SHALL never drop or duplicate a transaction; results SHALL retire in acceptance order.

Reset
REQ-030 On rst=1, s1_valid, s2_valid, S, C_out, overflow and zero SHALL go to 0 immediately, independent of clk.
REQ-031 While rst=1, in_ready SHALL be 1.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight transactions.
REQ-033 The first accepted transaction after rst deasserts SHALL emerge after 2 edges.

Configuration
REQ-034 Macro CLA_SATURATE_EN, when defined, SHALL clamp S on signed overflow:
- positive overflow clamps to 0x7F..F;
- negative overflow clamps to 0x80..0;
- overflow still reports 1, zero is computed on the clamped S, and C_out is unchanged.
REQ-035 Without CLA_SATURATE_EN, S SHALL be the wrap-around WIDTH-bit result, and no saturation logic SHALL be synthesised.

Verification (WIDTH=16)
REQ-036 A=0x7FFF, B=0x0001, sub=0, C_in=0 -> after 2 edges: S=0x8000, overflow=1, C_out=0, zero=0; with CLA_SATURATE_EN: S=0x7FFF.
REQ-037 A=0x0005, B=0x0005, sub=1 -> S=0x0000, zero=1, C_out=1, overflow=0; A=0x0000, B=0x0001, sub=1 -> S=0xFFFF, C_out=0.
REQ-038 A=0xFFFF, B=0x0000, C_in=1, sub=0 -> S=0x0000, C_out=1, zero=1; this exercises carry propagation across all four groups.
REQ-039 Stream 8 back-to-back transactions, then hold out_ready=0 for 3 cycles -> in_ready falls to 0 after 2 more acceptances, S is stable while stalled, and all 8 results are in order with no loss.
REQ-040 Assert rst for 1 cycle with 2 transactions in flight -> out_valid=0 immediately, neither result ever appears, and in_ready=1.
REQ-041 Randomised 10,000 transactions with random in_valid/out_ready -> every result matches a reference model of (A op B) mod 2^16, including flags.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Stage 1 registers the operands with B pre-inverted for subtraction and the
// effective carry-in; stage 2 registers the sum and its flags.
// Optional feature: define CLA_SATURATE_EN to clamp S on signed overflow.
module pipelined_cla_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NG = WIDTH / 4;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_cin;
    logic             s2_valid;
    logic             adv1;
    logic             adv2;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] bit_c;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [NG:0]      grp_c;
    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] sum_n;
    logic             c_out_n;
    logic             ovf_n;

    // A stage moves forward when it is empty or the stage after it is moving.
    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;

    // Stage 1 captures operands, folding subtraction into an inverted B and forced carry-in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cin   <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a   <= A;
                s1_b   <= B ^ {WIDTH{sub}};
                s1_cin <= sub ? 1'b1 : C_in;
            end
        end
    end

    assign g = s1_a & s1_b;
    assign p = s1_a ^ s1_b;

    // Each 4-bit group produces its own Pg/Gg and expands its internal carries from the group carry-in.
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        localparam int L = 4 * gi;
        assign grp_p[gi]  = &p[L+3:L];
        assign grp_g[gi]  = g[L+3]
                          | (p[L+3] & g[L+2])
                          | (p[L+3] & p[L+2] & g[L+1])
                          | (p[L+3] & p[L+2] & p[L+1] & g[L]);
        assign bit_c[L]   = grp_c[gi];
        assign bit_c[L+1] = g[L] | (p[L] & grp_c[gi]);
        assign bit_c[L+2] = g[L+1] | (p[L+1] & g[L]) | (p[L+1] & p[L] & grp_c[gi]);
        assign bit_c[L+3] = g[L+2] | (p[L+2] & g[L+1]) | (p[L+2] & p[L+1] & g[L])
                          | (p[L+2] & p[L+1] & p[L] & grp_c[gi]);
    end

    // Second-level lookahead: every group carry is a flat sum of products of Gg/Pg and carry-in.
    always_comb begin
        logic term;
        logic acc;
        grp_c    = '0;
        grp_c[0] = s1_cin;
        for (int k = 1; k <= NG; k++) begin
            term = s1_cin;
            for (int j = 0; j < k; j++) begin
                term = term & grp_p[j];
            end
            acc = term;
            for (int j = 0; j < k; j++) begin
                term = grp_g[j];
                for (int m = j + 1; m < k; m++) begin
                    term = term & grp_p[m];
                end
                acc = acc | term;
            end
            grp_c[k] = acc;
        end
    end

    assign raw_sum = p ^ bit_c;
    assign c_out_n = grp_c[NG];
    assign ovf_n   = bit_c[WIDTH-1] ^ c_out_n;

`ifdef CLA_SATURATE_EN
    // On overflow both effective operands share a sign, so A's sign picks the clamp direction.
    always_comb begin
        sum_n = raw_sum;
        if (ovf_n) begin
            sum_n = s1_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum_n = raw_sum;
`endif

    // Stage 2 holds the result under backpressure and only reloads it when stage 1 has data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            S        <= '0;
            C_out    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                S        <= sum_n;
                C_out    <= c_out_n;
                overflow <= ovf_n;
                zero     <= (sum_n == '0);
            end
        end
    end

endmodule
